// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch
// Description : Instruction-fetch stage. Holds the PC, issues in-order
//               requests over a req/gnt + rsp handshake, buffers returned
//               instructions in a 2-entry FIFO and presents them to the
//               IF/ID register with valid/ready. Redirects flush the FIFO
//               and discard in-flight wrong-path responses.
// Options     : `define IF_EXCP_MISALIGN_EN adds if_excp_misalign_o and turns
//               a misaligned redirect target into a single exception entry.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch #(
  parameter int unsigned                PC_WIDTH    = 32,
  parameter int unsigned                INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]        RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0]     NOP_INSTR   = INSTR_WIDTH'(32'h0000_0013)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect_i,
  input  logic [PC_WIDTH-1:0]    redirect_pc_i,
  input  logic                   id_ready_i,
  output logic                   imem_req_o,
  output logic [PC_WIDTH-1:0]    imem_addr_o,
  input  logic                   imem_gnt_i,
  input  logic                   imem_rsp_valid_i,
  input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
  output logic                   if_valid_o,
  output logic [PC_WIDTH-1:0]    if_pc_o,
  output logic [INSTR_WIDTH-1:0] if_instr_o
`ifdef IF_EXCP_MISALIGN_EN
  ,
  output logic                   if_excp_misalign_o
`endif
);

  // Combined budget of requests in flight plus buffered entries.
  localparam logic [2:0] CREDITS = 3'd2;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [PC_WIDTH-1:0]    fetch_pc_q,    fetch_pc_d;
  logic [PC_WIDTH-1:0]    rsp_pc_q,      rsp_pc_d;
  logic [1:0]             outstanding_q, outstanding_d;
  logic [1:0]             drop_cnt_q,    drop_cnt_d;
  logic [1:0]             fifo_cnt_q,    fifo_cnt_d;
  logic                   rd_ptr_q,      rd_ptr_d;
  logic                   wr_ptr_q,      wr_ptr_d;
  logic [PC_WIDTH-1:0]    fifo_pc_q    [2];
  logic [PC_WIDTH-1:0]    fifo_pc_d    [2];
  logic [INSTR_WIDTH-1:0] fifo_instr_q [2];
  logic [INSTR_WIDTH-1:0] fifo_instr_d [2];
`ifdef IF_EXCP_MISALIGN_EN
  logic                   fifo_mis_q   [2];
  logic                   fifo_mis_d   [2];
  logic                   halt_q,        halt_d;
`endif

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic [PC_WIDTH-1:0] redirect_tgt;
  logic [2:0]          inflight;
  logic                credit_ok;
  logic                fetch_en;
  logic                gnt_fire;
  logic                rsp_fire;
  logic                rsp_drop;
  logic                fifo_empty;
  logic                push;
  logic                pop;

`ifdef IF_EXCP_MISALIGN_EN
  logic                misalign_redirect;
  assign redirect_tgt      = redirect_pc_i;
  assign misalign_redirect = redirect_i & (redirect_pc_i[1:0] != 2'b00);
  // A misaligned target parks the fetcher until the next redirect.
  assign fetch_en          = ~halt_q;
`else
  // Without the exception path the target is silently word-aligned.
  logic                unused_redirect_lsbs;
  assign redirect_tgt         = {redirect_pc_i[PC_WIDTH-1:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];
  assign fetch_en             = 1'b1;
`endif

  // Requests in flight plus buffered entries never exceed the FIFO depth,
  // so a response always has a free slot waiting for it.
  assign inflight   = {1'b0, outstanding_q} + {1'b0, fifo_cnt_q};
  assign credit_ok  = inflight < CREDITS;

  assign imem_req_o  = ~rst & ~redirect_i & credit_ok & fetch_en;
  assign imem_addr_o = fetch_pc_q;

  assign gnt_fire   = imem_req_o & imem_gnt_i;
  // A response with nothing outstanding cannot belong to us; ignore it.
  assign rsp_fire   = imem_rsp_valid_i & (outstanding_q != 2'd0);
  assign rsp_drop   = rsp_fire & (drop_cnt_q != 2'd0);

  assign fifo_empty = (fifo_cnt_q == 2'd0);
  assign push       = rsp_fire & ~rsp_drop & ~redirect_i;
  assign pop        = ~fifo_empty & id_ready_i & ~redirect_i;

  // --------------------------------------------------------------------------
  // Output: zero-latency read straight from the FIFO head
  // --------------------------------------------------------------------------
  assign if_valid_o = ~fifo_empty;
  assign if_pc_o    = fifo_empty ? '0        : fifo_pc_q[rd_ptr_q];
  assign if_instr_o = fifo_empty ? NOP_INSTR : fifo_instr_q[rd_ptr_q];
`ifdef IF_EXCP_MISALIGN_EN
  assign if_excp_misalign_o = ~fifo_empty & fifo_mis_q[rd_ptr_q];
`endif

  // Next-state computation for PC, credit counters and FIFO contents.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    fifo_cnt_d    = fifo_cnt_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    fifo_pc_d     = fifo_pc_q;
    fifo_instr_d  = fifo_instr_q;
`ifdef IF_EXCP_MISALIGN_EN
    fifo_mis_d    = fifo_mis_q;
    halt_d        = halt_q;
`endif

    // Outstanding tracks the bus regardless of redirects; grant is already
    // masked off during a redirect because the request is suppressed.
    outstanding_d = outstanding_q + 2'(gnt_fire) - 2'(rsp_fire);

    if (redirect_i) begin
      fetch_pc_d = redirect_tgt;
      rsp_pc_d   = redirect_tgt;
      // Everything still owed by memory after this cycle is wrong-path,
      // including responses that were already scheduled for dropping.
      drop_cnt_d = outstanding_d;
      fifo_cnt_d = 2'd0;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
`ifdef IF_EXCP_MISALIGN_EN
      halt_d = misalign_redirect;
      if (misalign_redirect) begin
        fifo_pc_d[0]    = redirect_pc_i;
        fifo_instr_d[0] = NOP_INSTR;
        fifo_mis_d[0]   = 1'b1;
        fifo_cnt_d      = 2'd1;
        wr_ptr_d        = 1'b1;
      end
`endif
    end else begin
      if (gnt_fire) begin
        fetch_pc_d = fetch_pc_q + PC_WIDTH'(4);
      end
      if (rsp_drop) begin
        drop_cnt_d = drop_cnt_q - 2'd1;
      end
      if (push) begin
        fifo_pc_d[wr_ptr_q]    = rsp_pc_q;
        fifo_instr_d[wr_ptr_q] = imem_rdata_i;
`ifdef IF_EXCP_MISALIGN_EN
        fifo_mis_d[wr_ptr_q]   = 1'b0;
`endif
        wr_ptr_d = ~wr_ptr_q;
        rsp_pc_d = rsp_pc_q + PC_WIDTH'(4);
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      fifo_cnt_d = fifo_cnt_q + 2'(push) - 2'(pop);
    end
  end

  // Register all state; reset returns to an empty, idle fetcher at RESET_PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= 2'd0;
      drop_cnt_q    <= 2'd0;
      fifo_cnt_q    <= 2'd0;
      rd_ptr_q      <= 1'b0;
      wr_ptr_q      <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fifo_pc_q[i]    <= '0;
        fifo_instr_q[i] <= NOP_INSTR;
`ifdef IF_EXCP_MISALIGN_EN
        fifo_mis_q[i]   <= 1'b0;
`endif
      end
`ifdef IF_EXCP_MISALIGN_EN
      halt_q        <= 1'b0;
`endif
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      fifo_cnt_q    <= fifo_cnt_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      for (int i = 0; i < 2; i++) begin
        fifo_pc_q[i]    <= fifo_pc_d[i];
        fifo_instr_q[i] <= fifo_instr_d[i];
`ifdef IF_EXCP_MISALIGN_EN
        fifo_mis_q[i]   <= fifo_mis_d[i];
`endif
      end
`ifdef IF_EXCP_MISALIGN_EN
      halt_q        <= halt_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch
// Description : Directed self-checking bench for if_fetch with a small
//               in-order instruction memory model (1-cycle latency when
//               responses are enabled) and an in-order output stream check.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        id_ready_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rdata_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;
`ifdef IF_EXCP_MISALIGN_EN
  logic        if_excp_misalign_o;
`endif

  int checks = 0;
  int errors = 0;

  // memory model and sampled DUT outputs
  logic [31:0] pending [$];
  logic        rsp_en;
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc, s_instr;
`ifdef IF_EXCP_MISALIGN_EN
  logic        s_mis;
`endif
  logic [31:0] exp_pc;

  if_fetch dut (
    .clk              (clk),
    .rst              (rst),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .id_ready_i       (id_ready_i),
    .imem_req_o       (imem_req_o),
    .imem_addr_o      (imem_addr_o),
    .imem_gnt_i       (imem_gnt_i),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rdata_i     (imem_rdata_i),
    .if_valid_o       (if_valid_o),
    .if_pc_o          (if_pc_o),
    .if_instr_o       (if_instr_o)
`ifdef IF_EXCP_MISALIGN_EN
    ,
    .if_excp_misalign_o (if_excp_misalign_o)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h0) return 32'h0010_0093;
    else if (a == 32'h4) return 32'h0020_0113;
    else return 32'hA000_0000 ^ a;
  endfunction

  // One clock cycle: sample outputs mid-cycle, advance the memory model after
  // the edge, and check every accepted instruction against the expected stream.
  task automatic tick();
    logic fire, rsp_now;
    #1;
    s_req   = imem_req_o;
    s_addr  = imem_addr_o;
    s_valid = if_valid_o;
    s_pc    = if_pc_o;
    s_instr = if_instr_o;
`ifdef IF_EXCP_MISALIGN_EN
    s_mis   = if_excp_misalign_o;
`endif
    fire    = s_req && imem_gnt_i;
    rsp_now = imem_rsp_valid_i;
    if (!rst && s_valid && id_ready_i && !redirect_i) begin
      checks++;
      if (s_pc !== exp_pc || s_instr !== mem_data(exp_pc)) begin
        errors++;
        $display("FAIL stream: got pc %h instr %h, expected pc %h instr %h",
                 s_pc, s_instr, exp_pc, mem_data(exp_pc));
      end
      exp_pc = exp_pc + 32'd4;
    end
    if (rst) exp_pc = 32'h0;
    else if (redirect_i) exp_pc = {redirect_pc_i[31:2], 2'b00};
    @(posedge clk);
    #1;
    if (rst) begin
      pending.delete();
    end else begin
      if (rsp_now && pending.size() > 0) void'(pending.pop_front());
      if (fire) pending.push_back(s_addr);
    end
    if (!rst && rsp_en && pending.size() > 0) begin
      imem_rsp_valid_i = 1'b1;
      imem_rdata_i     = mem_data(pending[0]);
    end else begin
      imem_rsp_valid_i = 1'b0;
      imem_rdata_i     = 32'h0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    id_ready_i = 1'b1; imem_gnt_i = 1'b1; rsp_en = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    id_ready_i = 1'b1; imem_gnt_i = 1'b1; rsp_en = 1'b1;
    imem_rsp_valid_i = 1'b0; imem_rdata_i = 32'h0;
    tick(); tick();
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", s_req); end
    checks++; if (s_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", s_addr); end
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", s_valid); end
    checks++; if (s_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", s_pc); end
    checks++; if (s_instr !== 32'h13) begin errors++; $display("FAIL reset_instr: got %h expected 00000013", s_instr); end
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    do_reset();
    tick();
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h0 || s_valid !== 1'b0) begin errors++; $display("FAIL fetch_c0: got req %b addr %h valid %b expected 1 0 0", s_req, s_addr, s_valid); end
    tick();
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h4 || s_valid !== 1'b0) begin errors++; $display("FAIL fetch_c1: got req %b addr %h valid %b expected 1 4 0", s_req, s_addr, s_valid); end
    tick();
    checks++; if (s_valid !== 1'b1 || s_pc !== 32'h0 || s_instr !== 32'h0010_0093 || s_req !== 1'b0) begin errors++; $display("FAIL fetch_c2: got v %b pc %h instr %h req %b expected 1 0 00100093 0", s_valid, s_pc, s_instr, s_req); end
    tick();
    checks++; if (s_valid !== 1'b1 || s_pc !== 32'h4 || s_instr !== 32'h0020_0113 || s_addr !== 32'h8 || s_req !== 1'b1) begin errors++; $display("FAIL fetch_c3: got v %b pc %h instr %h req %b addr %h expected 1 4 00200113 1 8", s_valid, s_pc, s_instr, s_req, s_addr); end
    for (int i = 0; i < 12; i++) tick();
  endtask

  task automatic test_stall();
    do_reset();
    id_ready_i = 1'b0;
    tick(); tick();
    for (int i = 2; i < 8; i++) begin
      tick();
      checks++;
      if (s_valid !== 1'b1 || s_pc !== 32'h0 || s_req !== 1'b0) begin
        errors++; $display("FAIL stall_hold_%0d: got v %b pc %h req %b expected 1 0 0", i, s_valid, s_pc, s_req);
      end
    end
    id_ready_i = 1'b1;
    tick();
    tick();
    checks++; if (s_pc !== 32'h4 || s_req !== 1'b1 || s_addr !== 32'h8) begin errors++; $display("FAIL stall_resume: got pc %h req %b addr %h expected 4 1 8", s_pc, s_req, s_addr); end
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_gnt_hold();
    do_reset();
    imem_gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (s_req !== 1'b1 || s_addr !== 32'h0) begin errors++; $display("FAIL gnt_hold_%0d: got req %b addr %h expected 1 0", i, s_req, s_addr); end
    end
    imem_gnt_i = 1'b1;
    tick();
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h0) begin errors++; $display("FAIL gnt_first: got req %b addr %h expected 1 0", s_req, s_addr); end
    tick();
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h4) begin errors++; $display("FAIL gnt_second: got req %b addr %h expected 1 4", s_req, s_addr); end
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_redirect_drop();
    do_reset();
    tick(); tick(); tick();
    rsp_en = 1'b0;
    tick(); tick(); tick();
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL rd_full: got req %b expected 0", s_req); end
    rsp_en = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h100;
    tick();
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL rd_req_redir: got %b expected 0", s_req); end
    redirect_i = 1'b0;
    tick();
    checks++; if (s_req !== 1'b0 || s_valid !== 1'b0) begin errors++; $display("FAIL rd_c7: got req %b valid %b expected 0 0", s_req, s_valid); end
    tick();
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h100 || s_valid !== 1'b0) begin errors++; $display("FAIL rd_c8: got req %b addr %h valid %b expected 1 100 0", s_req, s_addr, s_valid); end
    tick();
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL rd_c9: got valid %b expected 0", s_valid); end
    tick();
    checks++; if (s_valid !== 1'b1 || s_pc !== 32'h100 || s_instr !== mem_data(32'h100)) begin errors++; $display("FAIL rd_first: got v %b pc %h instr %h expected 1 100 %h", s_valid, s_pc, s_instr, mem_data(32'h100)); end
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_redirect_same_cycle();
    do_reset();
    rsp_en = 1'b0;
    tick(); tick();
    rsp_en = 1'b1;
    tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h40;
    tick();
    checks++; if (s_req !== 1'b0 || imem_gnt_i !== 1'b1) begin errors++; $display("FAIL sc_redir_req: got req %b expected 0", s_req); end
    redirect_i = 1'b0;
    tick();
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h40 || s_valid !== 1'b0) begin errors++; $display("FAIL sc_c4: got req %b addr %h valid %b expected 1 40 0", s_req, s_addr, s_valid); end
    tick();
    checks++; if (s_valid !== 1'b0 || s_addr !== 32'h44) begin errors++; $display("FAIL sc_c5: got valid %b addr %h expected 0 44", s_valid, s_addr); end
    tick();
    checks++; if (s_valid !== 1'b1 || s_pc !== 32'h40 || s_instr !== mem_data(32'h40)) begin errors++; $display("FAIL sc_first: got v %b pc %h instr %h expected 1 40 %h", s_valid, s_pc, s_instr, mem_data(32'h40)); end
    for (int i = 0; i < 10; i++) tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    rsp_en = 1'b0;
    tick(); tick();
    rsp_en = 1'b1;
    tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h200;
    tick();
    redirect_pc_i = 32'h300;
    tick();
    redirect_i = 1'b0;
    tick();
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h300) begin errors++; $display("FAIL b2b_addr: got req %b addr %h expected 1 300", s_req, s_addr); end
    tick();
    checks++; if (s_addr !== 32'h304 || s_valid !== 1'b0) begin errors++; $display("FAIL b2b_c6: got addr %h valid %b expected 304 0", s_addr, s_valid); end
    tick();
    checks++; if (s_valid !== 1'b1 || s_pc !== 32'h300) begin errors++; $display("FAIL b2b_first: got v %b pc %h expected 1 300", s_valid, s_pc); end
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_wrap();
    do_reset();
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_i = 1'b0;
    tick();
    checks++; if (s_req !== 1'b1 || s_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_a: got req %b addr %h expected 1 fffffffc", s_req, s_addr); end
    tick();
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h0) begin errors++; $display("FAIL wrap_b: got req %b addr %h expected 1 0", s_req, s_addr); end
    tick();
    checks++; if (s_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc0: got %h expected fffffffc", s_pc); end
    tick();
    checks++; if (s_pc !== 32'h0) begin errors++; $display("FAIL wrap_pc1: got %h expected 0", s_pc); end
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_misalign();
    do_reset();
`ifdef IF_EXCP_MISALIGN_EN
    id_ready_i = 1'b0;
    redirect_i = 1'b1; redirect_pc_i = 32'h102;
    tick();
    redirect_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (s_req !== 1'b0 || s_valid !== 1'b1 || s_pc !== 32'h102 || s_mis !== 1'b1 || s_instr !== 32'h13) begin
        errors++; $display("FAIL mis_entry_%0d: got req %b v %b pc %h mis %b instr %h expected 0 1 102 1 00000013", i, s_req, s_valid, s_pc, s_mis, s_instr);
      end
    end
    redirect_i = 1'b1; redirect_pc_i = 32'h200;
    tick();
    redirect_i = 1'b0;
    tick();
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h200 || s_valid !== 1'b0 || s_mis !== 1'b0) begin errors++; $display("FAIL mis_recover: got req %b addr %h v %b mis %b expected 1 200 0 0", s_req, s_addr, s_valid, s_mis); end
    id_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) tick();
`else
    redirect_i = 1'b1; redirect_pc_i = 32'h102;
    tick();
    redirect_i = 1'b0;
    tick();
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h100) begin errors++; $display("FAIL align_addr: got req %b addr %h expected 1 100", s_req, s_addr); end
    tick(); tick();
    checks++; if (s_valid !== 1'b1 || s_pc !== 32'h100) begin errors++; $display("FAIL align_pc: got v %b pc %h expected 1 100", s_valid, s_pc); end
    for (int i = 0; i < 4; i++) tick();
`endif
  endtask

  initial begin
    exp_pc = 32'h0;
    test_reset();
    test_fetch();
    test_stall();
    test_gnt_hold();
    test_redirect_drop();
    test_redirect_same_cycle();
    test_back_to_back();
    test_wrap();
    test_misalign();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
